// File: rtl/lc3_alu_seq.sv
// Multi-cycle LC-3 ADD/AND/NOT execute stage driving a single-read-port register file.
// Operands are fetched one per cycle, then the result is written back and NZP updated.
module lc3_alu_seq #(
    parameter logic [2:0] RESET_NZP = 3'b010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  rf_out_reg,
    input  logic [15:0] rf_outdata,
    output logic [2:0]  rf_write_reg,
    output logic [15:0] rf_indata,
    output logic        rf_we,
    output logic [2:0]  nzp,
    output logic        done,
    output logic        illegal
);

    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpNot = 4'b1001;

    typedef enum logic [1:0] {StIdle, StRd1, StRd2, StWb} state_t;

    state_t      state_q;
    logic [15:0] instr_q;
    logic [15:0] op_a_q;
    logic [15:0] op_b_q;
    logic [2:0]  nzp_q;

    logic [3:0]  opcode;
    logic        legal;
    logic        reg_form;
    logic [15:0] result;
    logic [15:0] imm_sext;

    assign opcode   = instr_q[15:12];
    assign imm_sext = {{11{instr_q[4]}}, instr_q[4:0]};
    assign reg_form = (opcode == OpAdd || opcode == OpAnd) && !instr_q[5];

    always_comb begin
        legal  = 1'b1;
        result = 16'h0000;
        unique case (opcode)
            OpAdd:   result = op_a_q + op_b_q;
            OpAnd:   result = op_a_q & op_b_q;
            OpNot:   result = ~op_a_q;
            default: legal  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            instr_q <= 16'h0000;
            op_a_q  <= 16'h0000;
            op_b_q  <= 16'h0000;
            nzp_q   <= RESET_NZP;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= StRd1;
                    end
                end
                StRd1: begin
                    op_a_q <= rf_outdata;
                    if (reg_form) begin
                        state_q <= StRd2;
                    end else begin
                        op_b_q  <= imm_sext;
                        state_q <= StWb;
                    end
                end
                StRd2: begin
                    op_b_q  <= rf_outdata;
                    state_q <= StWb;
                end
                StWb: begin
                    // Exactly one flag set: N from sign, Z on zero, P otherwise.
                    if (legal) begin
                        nzp_q <= {result[15], result == 16'h0000,
                                  !result[15] && (result != 16'h0000)};
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode from registered state only; no input-to-output combinational path.
    always_comb begin
        instr_ready  = 1'b0;
        rf_out_reg   = 3'd0;
        rf_write_reg = 3'd0;
        rf_indata    = 16'h0000;
        rf_we        = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        unique case (state_q)
            StIdle: instr_ready = 1'b1;
            StRd1:  rf_out_reg  = instr_q[8:6];
            StRd2:  rf_out_reg  = instr_q[2:0];
            StWb: begin
                done = 1'b1;
                if (legal) begin
                    rf_we        = 1'b1;
                    rf_write_reg = instr_q[11:9];
                    rf_indata    = result;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: instr_ready = 1'b0;
        endcase
    end

    assign nzp = nzp_q;

endmodule
